// File: rtl/lpb_rd_if.sv
// Read-side handshake between the loopback checker (master) and a read data source (slave).
interface lpb_rd_if;
  logic        usb_rd;
  logic        usb_rdy;
  logic        usb_rd_valid;
  logic [15:0] usb_rdata;

  modport master (
    output usb_rd,
    input  usb_rdy,
    input  usb_rd_valid,
    input  usb_rdata
  );

  modport slave (
    input  usb_rd,
    output usb_rdy,
    output usb_rd_valid,
    output usb_rdata
  );
endinterface

// File: rtl/lpb_rd_responder.sv
// Loopback read responder: serves DEPTH+1 ramp words per burst, alternating up/down count,
// with programmable ready delay, LFSR-driven stalls and single-beat error injection.
module lpb_rd_responder #(
  parameter logic [31:0] DEPTH     = 32'hffffff,
  parameter int          RDY_DLY   = 16,
  parameter bit          STALL_EN  = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         usb_clk,
  input  logic         usb_rst,
  input  logic         enable,
  input  logic         read_start,
  lpb_rd_if.slave      rd_bus,
  input  logic         inject_err,
  output logic         burst_done,
  output logic [31:0]  words_sent
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [15:0] RDY_DLY_W = 16'(RDY_DLY);

  logic [1:0]  state_q, state_d;
  logic [15:0] dly_q, dly_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] words_q, words_d;
  logic [15:0] data_q, data_d;
  logic        loop_q, loop_d;
  logic        active_q, active_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        valid_q, valid_d;
  logic [15:0] rdata_q, rdata_d;

  logic lfsr_fb;
  logic stall;

  // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10).
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign stall   = STALL_EN && (lfsr_q[1:0] == 2'b00);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    dly_d       = dly_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    data_d      = data_q;
    loop_d      = loop_q;
    active_d    = active_q;
    lfsr_d      = lfsr_q;
    valid_d     = 1'b0;
    rdata_d     = rdata_q;

    if (state_q != ST_IDLE && !enable) begin
      // Abort: pattern data and direction survive so the next burst continues the ramp.
      state_d  = ST_IDLE;
      active_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && read_start) begin
            state_d     = ST_ARM;
            loop_d      = ~loop_q;
            remaining_d = DEPTH;
            words_d     = 32'd0;
            dly_d       = RDY_DLY_W;
            active_d    = 1'b1;
          end
        end
        ST_ARM: begin
          if (dly_q == 16'd0) state_d = ST_SERVE;
          else                dly_d   = dly_q - 16'd1;
        end
        ST_SERVE: begin
          lfsr_d = {lfsr_q[14:0], lfsr_fb};
          if (rd_bus.usb_rd && !stall && active_q) begin
            valid_d     = 1'b1;
            rdata_d     = data_q ^ {15'b0, inject_err};
            data_d      = loop_q ? data_q + 16'd1 : data_q - 16'd1;
            words_d     = words_q + 32'd1;
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd0) begin
              active_d = 1'b0;
              state_d  = ST_DONE;
            end
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state_q     <= ST_IDLE;
      dly_q       <= 16'd0;
      remaining_q <= 32'd0;
      words_q     <= 32'd0;
      data_q      <= 16'd0;
      loop_q      <= 1'b0;
      active_q    <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      valid_q     <= 1'b0;
      rdata_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      data_q      <= data_d;
      loop_q      <= loop_d;
      active_q    <= active_d;
      lfsr_q      <= lfsr_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rd_bus.usb_rdy      = (state_q == ST_SERVE);
  assign rd_bus.usb_rd_valid = valid_q;
  assign rd_bus.usb_rdata    = rdata_q;
  assign burst_done          = (state_q == ST_DONE);
  assign words_sent          = words_q;

endmodule
